// File: rtl/mux_rr_param.sv
// Parametrised registered N:1 mux with valid/ready handshake, fixed or round-robin
// channel selection, and a wrap-around count of completed output transfers.
module mux_rr_param #(
  parameter int WIDTH     = 2,
  parameter int CHANNELS  = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          selector,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          sel_out,
  input  logic                      ready_out,
  output logic [CNT_WIDTH-1:0]      contador
);

  logic                  r_valid;
  logic [WIDTH-1:0]      r_data;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      r_last;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_load;
  logic                  w_fix_grant;
  logic                  w_rr_grant;
  logic                  w_grant;
  logic                  w_xfer;
  logic [SEL_W-1:0]      w_fix_g;
  logic [SEL_W-1:0]      w_rr_g;
  logic [SEL_W-1:0]      w_g;
  logic [2*CHANNELS-1:0] w_rot;
  logic [WIDTH-1:0]      w_data;
  int                    w_rr_off;
  int                    w_rr_sum;

  // Output stage is one deep: it can take a new word when empty or draining.
  assign w_load = !r_valid || ready_out;

  // Loop compare keeps out-of-range selectors (non power-of-two CHANNELS) grant-free.
  always_comb begin
    w_fix_grant = 1'b0;
    w_fix_g     = selector;
    for (int k = 0; k < CHANNELS; k++) begin
      if (selector == SEL_W'(k) && valid_in[k]) begin
        w_fix_grant = 1'b1;
      end
    end
  end

  // Rotate so bit j is channel (last+1+j) mod CHANNELS; the lowest set bit wins.
  always_comb begin
    w_rot      = {valid_in, valid_in} >> (int'(r_last) + 1);
    w_rr_grant = 1'b0;
    w_rr_off   = 0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_rr_grant = 1'b1;
        w_rr_off   = j;
      end
    end
    w_rr_sum = int'(r_last) + 1 + w_rr_off;
    if (w_rr_sum >= CHANNELS) begin
      w_rr_sum = w_rr_sum - CHANNELS;
    end
    w_rr_g = SEL_W'(w_rr_sum);
  end

  assign w_grant = mode ? w_rr_grant : w_fix_grant;
  assign w_g     = mode ? w_rr_g     : w_fix_g;
  assign w_xfer  = w_load && w_grant && !reset;

  always_comb begin
    w_data   = '0;
    ready_in = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_g == SEL_W'(k)) begin
        w_data      = data_in[k*WIDTH +: WIDTH];
        ready_in[k] = w_xfer;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_last  <= SEL_W'(CHANNELS - 1);
    end else begin
      if (r_valid && ready_out) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_load) begin
        if (w_grant) begin
          r_data  <= w_data;
          r_sel   <= w_g;
          r_valid <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end
      // Fixed-mode transfers leave the round-robin pointer alone.
      if (w_xfer && mode) begin
        r_last <= w_g;
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign sel_out   = r_sel;
  assign contador  = r_cnt;

endmodule

// File: tb/tb_mux_rr_param.sv
// Directed bench for mux_rr_param: vector table for steady-state behaviour,
// hand sequences for counter wrap and reset during backpressure.
module tb_mux_rr_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic [1:0] selector;
  logic [7:0] data_in;
  logic [3:0] valid_in;
  logic [3:0] ready_in;
  logic [1:0] data_out;
  logic       valid_out;
  logic [1:0] sel_out;
  logic       ready_out;
  logic [5:0] contador;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mux_rr_param #(.WIDTH(2), .CHANNELS(4), .SEL_W(2), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .mode(mode), .selector(selector),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .sel_out(sel_out),
    .ready_out(ready_out), .contador(contador)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       md;
    logic [1:0] sel;
    logic [3:0] vin;
    logic       ro;
    logic [3:0] e_rdy;
    logic [1:0] e_d;
    logic       e_v;
    logic [1:0] e_s;
    logic [5:0] e_c;
  } vec_t;

  vec_t vt[$];

  task automatic add(input string nm, input logic rst, input logic md, input logic [1:0] sel,
                     input logic [3:0] vin, input logic ro, input logic [3:0] e_rdy,
                     input logic [1:0] e_d, input logic e_v, input logic [1:0] e_s,
                     input logic [5:0] e_c);
    vec_t v;
    v.name = nm; v.rst = rst; v.md = md; v.sel = sel; v.vin = vin; v.ro = ro;
    v.e_rdy = e_rdy; v.e_d = e_d; v.e_v = e_v; v.e_s = e_s; v.e_c = e_c;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic md, input logic [1:0] sel,
                       input logic [3:0] vin, input logic ro);
    reset = rst; mode = md; selector = sel; valid_in = vin; ready_out = ro;
  endtask

  task automatic chk_regs(input string nm, input logic [1:0] d, input logic v,
                          input logic [1:0] s, input logic [5:0] c);
    chk({nm, ".data_out"}, 32'(data_out), 32'(d));
    chk({nm, ".valid_out"}, 32'(valid_out), 32'(v));
    chk({nm, ".sel_out"}, 32'(sel_out), 32'(s));
    chk({nm, ".contador"}, 32'(contador), 32'(c));
  endtask

  initial begin
    data_in = 8'hE4;  // channel k carries value k
    drive(1'b1, 1'b0, 2'd0, 4'hF, 1'b1);

    //   name     rst md sel  vin    ro  rdy    d  v  s  cnt
    add("rst0",   1, 0, 2'd0, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    add("rst1",   1, 0, 2'd0, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    add("fix1",   0, 0, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 0);
    add("fix2",   0, 0, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 1);
    add("fix3",   0, 0, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 2);
    add("fix4",   0, 0, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 3);
    add("fix5",   0, 0, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 4);
    add("fix6",   0, 0, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 5);
    add("fixnv1", 0, 0, 2'd2, 4'hB, 1, 4'h0, 2, 0, 2, 6);
    add("fixnv2", 0, 0, 2'd2, 4'hB, 1, 4'h0, 2, 0, 2, 6);
    add("rr1",    0, 1, 2'd2, 4'hF, 1, 4'h1, 0, 1, 0, 6);
    add("rr2",    0, 1, 2'd2, 4'hF, 1, 4'h2, 1, 1, 1, 7);
    add("rr3",    0, 1, 2'd2, 4'hF, 1, 4'h4, 2, 1, 2, 8);
    add("rr4",    0, 1, 2'd2, 4'hF, 1, 4'h8, 3, 1, 3, 9);
    add("rr5",    0, 1, 2'd2, 4'hF, 1, 4'h1, 0, 1, 0, 10);
    add("rrskp1", 0, 1, 2'd2, 4'hD, 1, 4'h4, 2, 1, 2, 11);
    add("rrskp2", 0, 1, 2'd2, 4'hD, 1, 4'h8, 3, 1, 3, 12);
    add("rrskp3", 0, 1, 2'd2, 4'hD, 1, 4'h1, 0, 1, 0, 13);
    add("rrskp4", 0, 1, 2'd2, 4'hD, 1, 4'h4, 2, 1, 2, 14);
    add("rrskp5", 0, 1, 2'd2, 4'hD, 1, 4'h8, 3, 1, 3, 15);
    add("bp1",    0, 1, 2'd2, 4'hF, 0, 4'h0, 3, 1, 3, 15);
    add("bp2",    0, 1, 2'd2, 4'hF, 0, 4'h0, 3, 1, 3, 15);
    add("bp3",    0, 1, 2'd2, 4'hF, 0, 4'h0, 3, 1, 3, 15);
    add("bprel",  0, 1, 2'd2, 4'hF, 1, 4'h1, 0, 1, 0, 16);
    add("swfix",  0, 0, 2'd1, 4'hF, 1, 4'h2, 1, 1, 1, 17);
    add("swrr",   0, 1, 2'd1, 4'hF, 1, 4'h2, 1, 1, 1, 18);
    add("rrnone", 0, 1, 2'd1, 4'h0, 1, 4'h0, 1, 0, 1, 19);
    add("rrone",  0, 1, 2'd1, 4'h8, 1, 4'h8, 3, 1, 3, 19);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].md, vt[i].sel, vt[i].vin, vt[i].ro);
      #1;
      chk({vt[i].name, ".ready_in"}, 32'(ready_in), 32'(vt[i].e_rdy));
      @(posedge clk);
      #1;
      chk_regs(vt[i].name, vt[i].e_d, vt[i].e_v, vt[i].e_s, vt[i].e_c);
    end

    // Counter wrap: 64 handshakes after a fresh reset bring contador back to 0.
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 66; k++) begin
      drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d.sel_out", k), 32'(sel_out), 32'((k - 1) % 4));
      chk($sformatf("wrap%0d.contador", k), 32'(contador), 32'((k - 1) % 64));
    end

    // Stall the held word, then reset under backpressure.
    drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b0);
    #1;
    chk("stall.ready_in", 32'(ready_in), 32'h0);
    @(posedge clk);
    #1;
    chk_regs("stall", 2'd1, 1'b1, 2'd1, 6'd1);
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b0);
    #1;
    chk("midrst.ready_in", 32'(ready_in), 32'h0);
    @(posedge clk);
    #1;
    chk_regs("midrst", 2'd0, 1'b0, 2'd0, 6'd0);
    drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    #1;
    chk("restart.ready_in", 32'(ready_in), 32'h1);
    @(posedge clk);
    #1;
    chk_regs("restart", 2'd0, 1'b1, 2'd0, 6'd0);
    drive(1'b0, 1'b1, 2'd0, 4'hF, 1'b1);
    #1;
    chk("restart2.ready_in", 32'(ready_in), 32'h2);
    @(posedge clk);
    #1;
    chk_regs("restart2", 2'd1, 1'b1, 2'd1, 6'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_param.md
Name: mux_rr_param

Overview:
- Parametrised successor to the 2:1 registered behavioural mux.
- Selects one of CHANNELS input words of WIDTH bits into a single registered output stage with a valid/ready handshake.
- Two modes: fixed selection (selector-driven, as the 2:1 mux) and round-robin arbitration over the valid inputs.
- Keeps a wrap-around transfer counter for the bench to compare against, like contador_c; sits between the probador stimulus and the downstream consumer in both behavioural and synthesised benches.

Parameters:
- WIDTH, 2, bits per data word.
- CHANNELS, 4, number of input channels; legal range 2..8.
- SEL_W, 2, selector width; must equal ceil(log2(CHANNELS)).
- CNT_WIDTH, 6, width of the transfer counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- mode  in  1  0 = fixed selection, 1 = round-robin.
- selector  in  SEL_W  channel index used in fixed mode.
- data_in  in  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- valid_in  in  CHANNELS  per-channel valid.
- ready_in  out  CHANNELS  per-channel accept strobe (one-hot or zero).
- data_out  out  WIDTH  registered output word.
- valid_out  out  1  data_out holds an untaken word.
- sel_out  out  SEL_W  channel index that produced data_out.
- ready_out  in  1  downstream accepts data_out this cycle.
- contador  out  CNT_WIDTH  count of completed output handshakes.

Behaviour:
- Reset (reset=1 at a rising edge):
  - data_out, valid_out, sel_out and contador all go to 0.
  - Round-robin pointer last_g goes to CHANNELS-1, so channel 0 wins first.
  - ready_in is forced to 0 while reset is high.
  - Reset mid-transfer discards the held word; no handshake is counted that cycle.
- load = !valid_out || ready_out. The output register is a one-deep stage; load means it is empty or being drained this cycle.
- Grant g (combinational):
  - Fixed mode: g = selector if selector < CHANNELS and valid_in[selector]=1; otherwise no grant. Valid on other channels is ignored.
  - Round-robin mode: g is the first k with valid_in[k]=1, scanning last_g+1, last_g+2, … cyclically modulo CHANNELS. If no input is valid, there is no grant.
- ready_in[g] = load && grant && !reset. All other bits are 0. An input transfer occurs when valid_in[g] && ready_in[g].
- On the rising edge with load=1:
  - Grant present: data_out <= data_in[g], sel_out <= g, valid_out <= 1.
  - No grant: valid_out <= 0; data_out and sel_out hold their last values.
- On the rising edge with load=0 (valid_out=1, ready_out=0): data_out, sel_out and valid_out hold, and no input is accepted (backpressure).
- Latency: one cycle from input acceptance to valid_out. Full throughput (one word per cycle) while ready_out stays 1.
- last_g <= g on every input transfer in round-robin mode. In fixed mode last_g is untouched.
- contador increments by 1 on each cycle with valid_out && ready_out and wraps from 2^CNT_WIDTH-1 to 0. Simultaneous drain and refill counts once.
- Mode or selector changes take effect from the grant evaluated in the same cycle. A word already in the output register is unaffected. last_g is preserved across mode switches.
- valid_in may drop without a handshake; the block imposes no stability requirement on inputs.

Test Plan:
- Reset: hold reset=1 for 2 cycles with all valid_in=1 -> ready_in=0, data_out=0, valid_out=0, sel_out=0, contador=0. Release -> first word appears one cycle later.
- Fixed mode: CHANNELS=4, WIDTH=2, mode=0, selector=2, data_in={3,2,1,0} (ch3..ch0), all valid, ready_out=1 -> ready_in=4'b0100 every cycle, data_out=2, sel_out=2; after 5 cycles contador=5.
- Round-robin: mode=1, all valid, ready_out=1 -> sel_out sequence 0,1,2,3,0. Then drop valid_in[1] -> sequence skips channel 1 (…,0,2,3,0).
- Backpressure: valid_out=1 with data_out=3, then ready_out=0 for 3 cycles -> data_out=3 and sel_out held, ready_in=0, contador unchanged. Restore ready_out=1 -> contador+1 and a new word in the same cycle.
- Counter wrap: CNT_WIDTH=6, 64 consecutive handshakes -> contador returns to 0 at the 64th.
- Reset mid-operation: assert reset while valid_out=1 and ready_out=0 -> next cycle valid_out=0, contador=0. Round-robin restarts at channel 0.
